// File: rtl/chunked_adder.sv
// chunked_adder: N-bit add/subtract computed W bits per clock with valid/ready handshakes
module chunked_adder #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [N-1:0] y,
  output logic         c_out,
  output logic         overflow,
  output logic         o_valid,
  input  logic         o_ready
);
  localparam int NC = N / W;
  localparam int KW = NC > 1 ? $clog2(NC) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_a, r_b, r_y;
  logic          r_carry, r_cout, r_ovf;
  logic [KW-1:0] r_k;
  logic          w_accept, w_last;
  logic [W-1:0]  w_ca, w_cb;
  logic [W:0]    w_sum;
  assign w_accept = i_valid & i_ready;
  assign w_last   = r_k == KW'(NC - 1);
  assign w_ca     = r_a[int'(r_k) * W +: W];
  assign w_cb     = r_b[int'(r_k) * W +: W];
  assign w_sum    = (W + 1)'(w_ca) + (W + 1)'(w_cb) + (W + 1)'(r_carry);
  assign y        = r_y;
  assign c_out    = r_cout;
  assign overflow = r_ovf;
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: DONE with o_ready and i_valid re-enters RUN directly
  always_comb
    w_next = r_state == IDLE ? (i_valid ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) :
             r_state == DONE ? (o_ready ? (i_valid ? RUN : IDLE) : DONE) : IDLE;
  // handshake outputs
  always_comb begin
    i_ready = (r_state == IDLE) | ((r_state == DONE) & o_ready);
    o_valid = r_state == DONE;
  end
  // datapath: subtraction folds into inverted B with carry-in forced high
  always_ff @(posedge clk)
    if (rst) begin
      r_y     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub | c_in;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_y[int'(r_k) * W +: W] <= w_sum[W-1:0];
      r_carry <= w_sum[W];
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_cout <= w_sum[W];
        r_ovf  <= (r_a[N-1] == r_b[N-1]) & (w_sum[W-1] != r_a[N-1]);
      end
    end
endmodule
